regport_arbiter: RTL
====================

Name: regport_arbiter

Overview:
- Round-robin arbiter that shares one 16-entry, 16-bit register read port (the 16:1 register-select mux) among NREQ requesters, for example the decode, branch-compare and debug read paths.
- It samples requests, drives the mux select from the winner's register address, and captures the muxed word into a registered response tagged with the winner's ID.
- It is fully pipelined: one grant per cycle, with fixed latency.

Parameters:
- DW, 16, data width of the mux inputs/output.
- AW, 4, register address width (2^AW mux inputs).
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, equal to clog2(NREQ).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  arbitration enable; when low, no new grants are issued.
- req  in  NREQ  per-requester read request (level).
- addr  in  NREQ*AW  packed addresses; requester i uses addr[i*AW +: AW].
- ack  out  NREQ  one-hot grant acknowledge; a one-cycle pulse.
- sel  out  AW  select to the register mux.
- mux_data  in  DW  combinational output of the register mux.
- rdata  out  DW  captured read data.
- rvalid  out  1  rdata valid, one-cycle pulse.
- rid  out  IDW  requester ID for rdata.
- busy  out  1  a grant or response is in flight.

Behaviour:
- Reset (rst_n low at a clock edge) sets:
  - ack=0, sel=0, rdata=0, rvalid=0, rid=0, busy=0.
  - Round-robin pointer ptr=0, so requester 0 has the highest priority first.
  - All in-flight grants and responses are discarded; no response is emitted for them after reset releases.
- Stage A (arbitrate), evaluated at edge T when en=1 and req!=0:
  - Winner w is the first requester with req set, searching cyclically from ptr upward.
  - sel <= addr of w; ack <= one-hot(w); the tag register a_id <= w, a_v <= 1.
  - ptr <= (w+1) mod NREQ.
- Stage A idle case, when en=0 or req==0:
  - ack <= 0, a_v <= 0, ptr unchanged.
  - sel holds its last value; it must not glitch to 0.
- Stage B (capture), at edge T+1:
  - If a_v: rdata <= mux_data, rid <= a_id, rvalid <= 1.
  - Otherwise rvalid <= 0 and rdata/rid hold.
- Latency:
  - req sampled at edge T gives ack visible in cycle T..T+1.
  - rdata/rvalid are visible after edge T+1.
  - Request-to-data is 2 cycles.
- Throughput is one grant per cycle; back-to-back grants to different requesters are allowed.
- Requester handshake:
  - Hold req and addr stable until ack is seen high.
  - Deassert or change them in the cycle after ack, or keep req high to request again.
  - A requester holding req continuously receives a grant at most every NREQ cycles when all requesters contend, and every cycle when it is alone.
- Fairness: with all NREQ requesting, the grant sequence is strictly cyclic and starvation-free.
- ptr only advances on a grant.
- busy = a_v | (|ack). Note that ack and a_v are set together.
- en falling mid-stream: a grant already issued completes its stage B capture; only new grants stop.
- Widths: NREQ need not be a power of two. Wrap-around is mod NREQ, and pointer values ≥ NREQ are unreachable.
- Requests from indices ≥ NREQ do not exist; the req width is exactly NREQ.

Test Plan:
- Reset then single request:
  - Assert rst_n=0 for 2 cycles, then release.
  - Set req=0001, addr0=5, mux model returns 16'h1000+sel.
  - Required: ack=0001 one cycle later, sel=5, next cycle rvalid=1, rid=0, rdata=16'h1005, busy returns to 0.
- Full contention:
  - req=1111 held for 8 cycles with addr_i=i+8.
  - Required: ack sequence 0001,0010,0100,1000,0001,…; rdata sequence 16'h1008,1009,100A,100B,… with rid 0,1,2,3,…
- Pointer fairness:
  - After a grant to requester 2, raise req=0101 (requesters 0 and 2).
  - Required: next grant goes to requester 0 (search starts at 3 and wraps to 0), then requester 2.
- en gating:
  - Hold en=0 with req=0011.
  - Required: ack=0, rvalid=0, sel holds its prior value.
  - Raise en: next grant goes to requester 0 or 1 per ptr.
  - Drop en the cycle after a grant: that response still arrives with correct rdata.
- Reset mid-operation:
  - Assert rst_n=0 in the cycle between ack and rvalid.
  - Required: no rvalid afterwards, all outputs 0, and the next grant after release goes to requester 0.
- Idle/sel stability:
  - Grant addr=12, then set req=0 for 5 cycles.
  - Required: sel stays 12, rvalid pulses exactly once, rdata holds 16'h100C.

Source files
------------

// File: rtl/regport_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Stage A picks a winner and drives the mux select; stage B captures the muxed word.
module regport_arbiter #(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    ack,
  output logic [AW-1:0]      sel,
  input  logic [DW-1:0]      mux_data,
  output logic [DW-1:0]      rdata,
  output logic               rvalid,
  output logic [IDW-1:0]     rid,
  output logic               busy
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] ptr_nxt;
  logic           found;
  logic           grant;
  logic [AW-1:0]  win_addr;
  logic [NREQ-1:0] win_onehot;
  logic [IDW-1:0] id_p0;
  logic           vld_p0;
  int             j;

  // Cyclic search starting at ptr; the index stays below NREQ so the low IDW bits are exact.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j[IDW-1:0]]) begin
        found = 1'b1;
        win   = j[IDW-1:0];
      end
    end
  end

  assign grant      = en && found;
  assign win_addr   = addr[int'(win)*AW +: AW];
  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign ptr_nxt    = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr    <= '0;
      ack    <= '0;
      sel    <= '0;
      id_p0  <= '0;
      vld_p0 <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rid    <= '0;
    end else begin
      // Stage A: arbitrate; sel holds through idle cycles so the mux never glitches
      if (grant) begin
        sel    <= win_addr;
        ack    <= win_onehot;
        id_p0  <= win;
        vld_p0 <= 1'b1;
        ptr    <= ptr_nxt;
      end else begin
        ack    <= '0;
        vld_p0 <= 1'b0;
      end
      // Stage B: capture the muxed word for the grant issued last cycle
      rvalid <= vld_p0;
      if (vld_p0) begin
        rdata <= mux_data;
        rid   <= id_p0;
      end
    end
  end

  assign busy = vld_p0 | (|ack);

endmodule
